// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared states, ASCII constants and character classes for expr_checker
package expr_pkg;

  typedef enum logic [1:0] {
    EXP_OPND  = 2'd0,
    IN_NUM    = 2'd1,
    AFT_CLOSE = 2'd2,
    ERR       = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_DIG = 3'd0,
    C_OP  = 3'd1,
    C_LP  = 3'd2,
    C_RP  = 3'd3,
    C_SP  = 3'd4,
    C_BAD = 3'd5
  } cls_t;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_LPAR  = 8'h28;
  localparam logic [7:0] CH_RPAR  = 8'h29;
  localparam logic [7:0] CH_SPACE = 8'h20;

endpackage

// File: rtl/ascii_class.sv
// rtl/ascii_class.sv - combinational ASCII character classifier for expr_checker
module ascii_class
  import expr_pkg::*;
#(
  parameter bit ALLOW_SUB = 1'b0
) (
  input  logic [7:0] i_ch,
  output cls_t       o_cls
);

  always_comb begin
    o_cls = C_BAD;
    if (i_ch >= CH_0 && i_ch <= CH_9) begin
      o_cls = C_DIG;
    end else begin
      case (i_ch)
        CH_PLUS, CH_STAR: o_cls = C_OP;
        CH_MINUS:         o_cls = ALLOW_SUB ? C_OP : C_BAD;
        CH_LPAR:          o_cls = C_LP;
        CH_RPAR:          o_cls = C_RP;
        CH_SPACE:         o_cls = C_SP;
        default:          o_cls = C_BAD;
      endcase
    end
  end

endmodule

// File: rtl/expr_checker.sv
// rtl/expr_checker.sv - streaming arithmetic-expression validator (option: EXPR_SPACE_SKIP_EN)
module expr_checker
  import expr_pkg::*;
#(
  parameter int MAX_DEPTH  = 4,
  parameter int MAX_DIGITS = 8,
  parameter bit ALLOW_SUB  = 1'b0,
  localparam int DW = $clog2(MAX_DEPTH + 1),
  localparam int NW = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          restart,
  input  logic          in_valid,
  input  logic [7:0]    in,
  output logic          out,
  output logic          err,
  output logic [DW-1:0] depth,
  output logic [NW-1:0] ndig
);

  localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
  localparam logic [NW-1:0] NDIG_MAX  = NW'(MAX_DIGITS);
  localparam logic [NW-1:0] NDIG_ONE  = NW'(1);

  state_t        r_state, w_state_nx;
  logic [DW-1:0] r_depth, w_depth_nx;
  logic [NW-1:0] r_ndig, w_ndig_nx;
  logic          r_out, r_err;
  logic          w_skip;
  cls_t          w_cls;

  ascii_class #(.ALLOW_SUB(ALLOW_SUB)) u_class (
    .i_ch  (in),
    .o_cls (w_cls)
  );

`ifdef EXPR_SPACE_SKIP_EN
  assign w_skip = (w_cls == C_SP);
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_depth_nx = r_depth;
    w_ndig_nx  = r_ndig;
    if (in_valid && !w_skip) begin
      case (r_state)
        EXP_OPND: begin
          if (w_cls == C_DIG) begin
            w_state_nx = IN_NUM;
            w_ndig_nx  = NDIG_ONE;
          end else if (w_cls == C_LP && r_depth != DEPTH_MAX) begin
            w_depth_nx = r_depth + DEPTH_ONE;
          end else begin
            w_state_nx = ERR;
          end
        end
        IN_NUM: begin
          if (w_cls == C_DIG && r_ndig != NDIG_MAX) begin
            w_ndig_nx = r_ndig + NDIG_ONE;
          end else if (w_cls == C_OP) begin
            w_state_nx = EXP_OPND;
            w_ndig_nx  = '0;
          end else if (w_cls == C_RP && r_depth != '0) begin
            w_state_nx = AFT_CLOSE;
            w_depth_nx = r_depth - DEPTH_ONE;
            w_ndig_nx  = '0;
          end else begin
            w_state_nx = ERR;
          end
        end
        AFT_CLOSE: begin
          if (w_cls == C_OP) begin
            w_state_nx = EXP_OPND;
          end else if (w_cls == C_RP && r_depth != '0) begin
            w_depth_nx = r_depth - DEPTH_ONE;
          end else begin
            w_state_nx = ERR;
          end
        end
        default: w_state_nx = ERR;
      endcase
    end
  end

  // out/err are registered from next-state so they never glitch
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= EXP_OPND;
      r_depth <= '0;
      r_ndig  <= '0;
      r_out   <= 1'b0;
      r_err   <= 1'b0;
    end else if (restart) begin
      r_state <= EXP_OPND;
      r_depth <= '0;
      r_ndig  <= '0;
      r_out   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_depth <= w_depth_nx;
      r_ndig  <= w_ndig_nx;
      r_out   <= (w_state_nx == IN_NUM || w_state_nx == AFT_CLOSE) && (w_depth_nx == '0);
      r_err   <= (w_state_nx == ERR);
    end
  end

  assign out   = r_out;
  assign err   = r_err;
  assign depth = r_depth;
  assign ndig  = r_ndig;

endmodule

// File: tb/tb_expr_checker.sv
// tb/tb_expr_checker.sv - directed self-checking bench for expr_checker (default and small-limit instances)
module tb_expr_checker;

  logic       clk;
  logic       clr_n;
  logic       restart;
  logic       in_valid;
  logic [7:0] in;

  logic       out_a, err_a;
  logic [2:0] depth_a;
  logic [3:0] ndig_a;
  logic       out_b, err_b;
  logic [1:0] depth_b;
  logic [1:0] ndig_b;

  int n_checks;
  int n_errors;
  int max_depth_a;

  expr_checker dut_a (
    .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in),
    .out(out_a), .err(err_a), .depth(depth_a), .ndig(ndig_a)
  );

  expr_checker #(.MAX_DEPTH(2), .MAX_DIGITS(3), .ALLOW_SUB(1'b1)) dut_b (
    .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in),
    .out(out_b), .err(err_b), .depth(depth_b), .ndig(ndig_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] ch);
    @(negedge clk);
    in       = ch;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  // oa/ea/ob/eb hold per-character expected out/err for each instance as '0'/'1'
  task automatic run_vec(input string tag, input string s, input string oa, input string ea,
                         input string ob, input string eb);
    byte c;
    do_restart();
    max_depth_a = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      send(c);
      if (int'(depth_a) > max_depth_a) max_depth_a = int'(depth_a);
      check($sformatf("%s[%0d] out_a", tag, i), int'(out_a), int'(oa[i] == 8'h31));
      check($sformatf("%s[%0d] err_a", tag, i), int'(err_a), int'(ea[i] == 8'h31));
      check($sformatf("%s[%0d] out_b", tag, i), int'(out_b), int'(ob[i] == 8'h31));
      check($sformatf("%s[%0d] err_b", tag, i), int'(err_b), int'(eb[i] == 8'h31));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr_n    = 1'b0;
    restart  = 1'b0;
    in_valid = 1'b0;
    in       = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_a", int'(out_a), 0);
    check("reset err_a", int'(err_a), 0);
    check("reset depth_a", int'(depth_a), 0);
    check("reset ndig_a", int'(ndig_a), 0);
    @(negedge clk);
    clr_n = 1'b1;

    run_vec("12+3", "12+3", "1101", "0000", "1101", "0000");
    check("12+3 ndig_a", int'(ndig_a), 1);

    run_vec("nest", "(4*(5+6))", "000000001", "000000000", "000000001", "000000000");
    check("nest depth peak", max_depth_a, 2);
    check("nest final depth", int'(depth_a), 0);

    run_vec("deep", "(((1", "0000", "0000", "0000", "0011");
    check("deep depth_b hold", int'(depth_b), 2);

    run_vec("digits", "1234", "1111", "0000", "1110", "0001");
    check("digits ndig_a", int'(ndig_a), 4);
    check("digits ndig_b hold", int'(ndig_b), 3);
    run_vec("after restart", "7", "1", "0", "1", "0");

    run_vec("rpar", ")", "0", "1", "0", "1");
    run_vec("lead op", "+1", "00", "11", "00", "11");
    run_vec("dbl op", "1++2", "1000", "0011", "1000", "0011");
    run_vec("num lpar", "2(", "10", "01", "10", "01");
    run_vec("minus", "5-1", "100", "011", "101", "000");

`ifdef EXPR_SPACE_SKIP_EN
    run_vec("space", "1 + 2", "11001", "00000", "11001", "00000");
    run_vec("space in num", "1 2", "111", "000", "111", "000");
    check("space in num ndig_a", int'(ndig_a), 2);
`else
    run_vec("space", "1 + 2", "10000", "01111", "10000", "01111");
`endif

    do_restart();
    send("1");
    send("2");
    repeat (3) @(posedge clk);
    #1;
    check("idle hold out_a", int'(out_a), 1);
    check("idle hold ndig_a", int'(ndig_a), 2);

    run_vec("mid", "(3+", "000", "000", "000", "000");
    check("mid depth_a", int'(depth_a), 1);
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check("async depth_a", int'(depth_a), 0);
    check("async ndig_a", int'(ndig_a), 0);
    check("async out_a", int'(out_a), 0);
    check("async err_a", int'(err_a), 0);
    @(negedge clk);
    clr_n = 1'b1;
    send("9");
    check("post reset out_a", int'(out_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
